// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Control FSM for a multi-cycle MIPS datapath (shared memory, one
//            ALU, IR/A/B/ALUOut holding registers). Handles R-type, lw, sw,
//            beq, addi and j. Stalls on mem_ready, counts retired
//            instructions and traps illegal opcodes into a sticky ERR state.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_ERR      = 4'd15
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [5:0]       opcode_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  // Next-state selection; unused codes 12-14 fall into ERR via default
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          C_OP_RTYPE:       state_d = S_EXEC;
          C_OP_LW, C_OP_SW: state_d = S_MEMADDR;
          C_OP_BEQ:         state_d = S_BRANCH;
          C_OP_ADDI:        state_d = S_ADDIEX;
          C_OP_J:           state_d = S_JUMP;
          default:          state_d = S_ERR;
        endcase
      end
      // IR may have moved on; steer with the opcode captured in DECODE
      S_MEMADDR:  state_d = (opcode_q == C_OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_RWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      S_ERR:      state_d = S_ERR;
      default:    state_d = S_ERR;
    endcase
  end

  // Datapath control decode from current state (mem_ready gates fetch/store)
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched opcode, sticky trap and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opcode_q  <= 6'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (state_d == S_ERR) illegal_q <= 1'b1;
      if (instr_done) count_q <= count_q + C_CNT_ONE;
    end
  end

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Scoreboard bench for multicycle_control. A memory/IR responder
//            feeds opcodes and wait states; an instruction-level model
//            predicts latency and strobe counts per retired instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       opcode = 6'd0;
  logic             mem_ready = 1'b0;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       PCSource, ALUSrcB, ALUOp;
  logic [3:0]       state;
  logic             instr_done, illegal_op;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state),
    .instr_done(instr_done), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int memr; int memw; int ir; int pcw; int pcj;
    int pcwc; int regw; int regdst; int m2r; int st; int cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] prog_q[$];
  int         wait_q[$];
  bit         busy = 1'b0;
  int         wait_left = 0;
  int         checks = 0;
  int         passes = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  // Instruction-level model: latency and strobe totals from the opcode and
  // the wait states the memory will insert.
  task automatic gen(input logic [5:0] op, input int f, input int m, input int idx);
    exp_t e;
    bit is_lw, is_sw;
    is_lw = (op == 6'b100011);
    is_sw = (op == 6'b101011);
    case (op)
      6'b000000: begin e.cyc = 4; e.st = 7;  end
      6'b100011: begin e.cyc = 5; e.st = 4;  end
      6'b101011: begin e.cyc = 4; e.st = 5;  end
      6'b000100: begin e.cyc = 3; e.st = 8;  end
      6'b000010: begin e.cyc = 3; e.st = 9;  end
      default:   begin e.cyc = 4; e.st = 11; end
    endcase
    e.cyc    = e.cyc + f + ((is_lw || is_sw) ? m : 0);
    e.memr   = 1 + f + (is_lw ? 1 + m : 0);
    e.memw   = is_sw ? 1 + m : 0;
    e.ir     = 1;
    e.pcj    = (op == 6'b000010) ? 1 : 0;
    e.pcw    = 1 + e.pcj;
    e.pcwc   = (op == 6'b000100) ? 1 : 0;
    e.regw   = (op == 6'b000000 || is_lw || op == 6'b001000) ? 1 : 0;
    e.regdst = (op == 6'b000000) ? 1 : 0;
    e.m2r    = is_lw ? 1 : 0;
    e.cnt    = idx % (1 << CNT_W);
    prog_q.push_back(op);
    wait_q.push_back(f);
    if (is_lw || is_sw) wait_q.push_back(m);
    exp_q.push_back(e);
  endtask

  // IR and memory responder: opcode is valid only in the cycle after an IR
  // load; each memory access consumes one wait count from wait_q.
  initial begin : driver
    bit ir_load;
    forever begin
      @(negedge clk);
      ir_load = IRWrite;
      @(posedge clk);
      #1;
      if (ir_load && prog_q.size() > 0) opcode = prog_q.pop_front();
      else opcode = 6'($urandom);
      if (MemRead || MemWrite) begin
        if (!busy) begin
          busy = 1'b1;
          wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 1000000;
        end
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          busy = 1'b0;
        end else begin
          mem_ready = 1'b0;
          wait_left--;
        end
      end else begin
        mem_ready = 1'($urandom);
      end
    end
  end

  // Monitor: accumulate per-instruction observations, compare on retire
  initial begin : monitor
    int a_cyc, a_memr, a_memw, a_ir, a_pcw, a_pcj, a_pcwc, a_regw, a_regdst, a_m2r;
    exp_t e;
    a_cyc = 0; a_memr = 0; a_memw = 0; a_ir = 0; a_pcw = 0;
    a_pcj = 0; a_pcwc = 0; a_regw = 0; a_regdst = 0; a_m2r = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_cyc = 0; a_memr = 0; a_memw = 0; a_ir = 0; a_pcw = 0;
        a_pcj = 0; a_pcwc = 0; a_regw = 0; a_regdst = 0; a_m2r = 0;
        continue;
      end
      a_cyc++;
      if (MemRead) a_memr++;
      if (MemWrite) a_memw++;
      if (IRWrite) a_ir++;
      if (PCWrite) a_pcw++;
      if (PCWrite && PCSource == 2'b10) a_pcj++;
      if (PCWriteCond && PCSource == 2'b01) a_pcwc++;
      if (RegWrite) a_regw++;
      if (RegWrite && RegDst) a_regdst++;
      if (RegWrite && MemtoReg) a_m2r++;
      if (instr_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", a_cyc, e.cyc);
          chk("retire_state", int'(state), e.st);
          chk("count_before_retire", int'(instr_count), e.cnt);
          chk("memread_cycles", a_memr, e.memr);
          chk("memwrite_cycles", a_memw, e.memw);
          chk("irwrite_cycles", a_ir, e.ir);
          chk("pcwrite_cycles", a_pcw, e.pcw);
          chk("jump_pcwrite", a_pcj, e.pcj);
          chk("branch_pcwritecond", a_pcwc, e.pcwc);
          chk("regwrite_cycles", a_regw, e.regw);
          chk("regdst_writes", a_regdst, e.regdst);
          chk("memtoreg_writes", a_m2r, e.m2r);
        end
        a_cyc = 0; a_memr = 0; a_memw = 0; a_ir = 0; a_pcw = 0;
        a_pcj = 0; a_pcwc = 0; a_regw = 0; a_regdst = 0; a_m2r = 0;
      end
    end
  end

  // Hold reset for a few cycles, check reset values, then flush stimulus.
  // Returns at negedge+1 with rst still high.
  task automatic hold_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_illegal", int'(illegal_op), 0);
    chk("reset_count", int'(instr_count), 0);
    chk("reset_memwrite", int'(MemWrite), 0);
    repeat (2) @(negedge clk);
    #1;
    exp_q.delete();
    prog_q.delete();
    wait_q.delete();
    busy = 1'b0;
  endtask

  initial begin : main
    logic [5:0] ops [6];
    int n, bad, total;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

    // Directed opening sequence then randomized program
    hold_reset();
    total = 40;
    gen(6'b000000, 0, 0, 0);
    gen(6'b100011, 3, 2, 1);
    gen(6'b101011, 0, 2, 2);
    gen(6'b000100, 0, 0, 3);
    gen(6'b000010, 0, 0, 4);
    gen(6'b001000, 0, 0, 5);
    for (int i = 6; i < total; i++)
      gen(ops[$urandom_range(0, 5)],
          ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
          $urandom_range(0, 3), i);
    rst = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("program_completed_in_budget", exp_q.size(), 0);
    @(negedge clk);
    chk("final_count_wrapped", int'(instr_count), total % (1 << CNT_W));
    chk("no_trap_on_legal_program", int'(illegal_op), 0);

    // Illegal opcode traps into ERR and stays quiet
    hold_reset();
    prog_q.push_back(6'b111111);
    wait_q.push_back(0);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state != 4'd15 && n < 20);
    chk("err_entry_cycle", n, 3);
    chk("err_illegal_set", int'(illegal_op), 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state != 4'd15 || !illegal_op || instr_done || PCWrite || PCWriteCond ||
          MemRead || MemWrite || IRWrite || RegWrite || MemtoReg || RegDst ||
          IorD || ALUSrcA || PCSource != 2'b00 || ALUSrcB != 2'b00 || ALUOp != 2'b00)
        bad++;
    end
    chk("err_quiet_cycles", bad, 0);
    chk("err_count_zero", int'(instr_count), 0);

    // Reset while a store is waiting on memory
    hold_reset();
    prog_q.push_back(6'b101011);
    wait_q.push_back(0);
    wait_q.push_back(6);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!MemWrite && n < 20);
    chk("store_reached_memwrite", int'(MemWrite), 1);
    @(negedge clk);
    chk("store_still_waiting", int'(state), 5);
    chk("store_no_early_retire", int'(instr_done), 0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midstore_reset_state", int'(state), 0);
    chk("midstore_reset_memwrite", int'(MemWrite), 0);
    chk("midstore_reset_count", int'(instr_count), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy control FSM that sequences a multi-cycle MIPS datapath with one shared memory, one ALU, and IR/A/B/ALUOut holding registers.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j.
- Stalls on a memory ready handshake.
- Counts retired instructions and traps on illegal opcodes.
- Sits between the instruction register's opcode field and the datapath muxes, register file, memory and PC write enables.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load IR.
- MemtoReg  out  1  register write data: 0 ALUOut, 1 MDR.
- RegDst  out  1  register write index: 0 rt, 1 rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 PC, 1 A.
- ALUSrcB  out  2  ALU B input: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- ALUOp  out  2  to ALU control: 00 add, 01 sub, 10 funct.
- state  out  4  current state, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  sticky trap flag.
- instr_count  out  CNT_W  retired instruction count.

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous and active-high. rst has priority over every other event.
- Reset values: state=FETCH, instr_count=0, illegal_op=0.
- Output decode: all outputs decode combinationally from state (plus mem_ready where noted). Any output not listed for a state is 0; outputs are never X.
- State encoding: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ERR=15. Codes 12-14 are unreachable; if entered, they go to ERR.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready.
  - Transition: stay while mem_ready=0, else DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target).
  - Next state by opcode: 000000 EXEC, 100011/101011 MEMADDR, 000100 BRANCH, 001000 ADDIEX, 000010 JUMP, anything else ERR.
- MEMADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEMREAD if the latched opcode is lw, else MEMWRITE. The opcode is latched internally in DECODE and IR is not re-read.
- MEMREAD: MemRead=1, IorD=1. Stay while mem_ready=0, else MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Retires; next FETCH.
- MEMWRITE: MemWrite=1, IorD=1, held for every wait cycle. Stay while mem_ready=0; retires and goes to FETCH when mem_ready=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1. Retires; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Retires; next FETCH.
- JUMP: PCWrite=1, PCSource=10. Retires; next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Retires; next FETCH.
- ERR: all control outputs 0. illegal_op is set on entry and stays set. Remains in ERR until rst.
- Retirement:
  - instr_done=1 during the final cycle of an instruction: MEMWB, RWB, BRANCH, JUMP, ADDIWB, and MEMWRITE only when mem_ready=1.
  - instr_count increments by 1 on the same edge and wraps from 2^CNT_W-1 to 0 with no flag.
- Latencies with mem_ready tied 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset mid-instruction: a pending write is dropped and the count is not incremented. MEMWRITE is a combinational decode of state, so it is 0 from the reset edge onward.

Test Plan:
- Reset, then R-type opcode 000000 with mem_ready=1 → states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in cycle 4. instr_done pulses once; instr_count=1.
- lw (100011) with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD → FETCH held 4 cycles with IRWrite=0 until ready. Total 10 cycles. MemtoReg=1 in MEMWB; instr_count=1.
- sw (101011) with mem_ready low 2 cycles in MEMWRITE → MemWrite=1 for 3 consecutive cycles. instr_done only on the ready cycle; RegWrite never 1.
- Sequence beq, j, addi back-to-back with mem_ready=1 → 3+3+4=10 cycles. PCWriteCond=1/PCSource=01 in BRANCH, PCWrite=1/PCSource=10 in JUMP. instr_count=3.
- Opcode 111111 → ERR after DECODE. illegal_op=1, all strobes 0 for 20 cycles. rst → state=0, illegal_op=0, count=0.
- rst asserted during MEMWRITE wait → next cycle state=FETCH, MemWrite=0, instr_count unchanged from reset value 0.
